// File: rtl/duty_cycle_meter.sv
// ----------------------------------------------------------------------------
// duty_cycle_meter
//
// Measures a pulse train one period at a time. For each period it reports the
// number of synchronized-high clk cycles and the period length in clk cycles.
// A period runs from one detected rising edge to the next. Results are offered
// on a valid/ready interface.
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   rst         in   1      asynchronous active-high reset
//   sig_in      in   1      pulse train under measurement (asynchronous)
//   clr         in   1      synchronous clear: back to IDLE, flags cleared,
//                           pending result dropped
//   meas_ready  in   1      consumer takes the result when meas_valid is high
//   meas_valid  out  1      a result is held on high_cnt/period_cnt/meas_ovf
//   high_cnt    out  CNT_W  synced-high cycles in the measured period
//   period_cnt  out  CNT_W  cycles from one detected rise to the next
//   meas_ovf    out  1      a counter saturated during this measurement
//   drop_flag   out  1      sticky: a finished result was lost to backpressure
//   active      out  1      high while a period is being measured
// ----------------------------------------------------------------------------
module duty_cycle_meter #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             clr,
   input  logic             meas_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_ovf,
   output logic             drop_flag,
   output logic             active
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_p;
   logic                   s, prev, rise, fall;
   logic [CNT_W-1:0]       cnt, high_lat;
   logic                   ovf_acc;
   logic [CNT_W:0]         inc;
   logic                   close, accept;

   // Saturating increment: MSB of the result flags an attempted overflow.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX)
         return {1'b1, CNT_MAX};
      else
         return {1'b0, v + CNT_ONE};
   endfunction

   // Input synchronizer and edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p <= '0;
         prev   <= 1'b0;
      end else begin
         sync_p[0] <= sig_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_p[i] <= sync_p[i-1];
         prev <= s;
      end
   end

   assign s    = sync_p[SYNC_STAGES-1];
   assign rise = s & ~prev;
   assign fall = ~s & prev;

   // FSM: leaves MEASURE only through clr or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rise) state_nxt = MEASURE;
         MEASURE: state_nxt = MEASURE;
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   assign active = (state == MEASURE);
   assign inc    = sat_inc(cnt);
   assign close  = (state == MEASURE) && rise;
   assign accept = meas_valid && meas_ready;

   // Counters and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         high_lat   <= '0;
         ovf_acc    <= 1'b0;
         meas_valid <= 1'b0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_ovf   <= 1'b0;
         drop_flag  <= 1'b0;
      end else if (clr) begin
         // Result fields are left as-is; meas_valid=0 marks them stale.
         cnt        <= '0;
         ovf_acc    <= 1'b0;
         meas_valid <= 1'b0;
         drop_flag  <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (rise) begin
               cnt     <= CNT_ONE;
               ovf_acc <= 1'b0;
            end
         end else begin
            if (rise) begin
               cnt     <= CNT_ONE;
               ovf_acc <= 1'b0;
            end else begin
               cnt <= inc[CNT_W-1:0];
               if (inc[CNT_W]) ovf_acc <= 1'b1;
            end
            if (fall) high_lat <= cnt;
         end

         // A closing period may replace the held result only if the old one
         // is being taken on this same edge; otherwise the new one is lost.
         if (close && (!meas_valid || accept)) begin
            high_cnt   <= high_lat;
            period_cnt <= cnt;
            meas_ovf   <= ovf_acc;
            meas_valid <= 1'b1;
         end else begin
            if (accept) meas_valid <= 1'b0;
            if (close)  drop_flag  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Bench for duty_cycle_meter: an 8-bit instance (dut_a) for most scenarios and
// a 4-bit instance (dut_b) for the saturation case. Expected results are
// queued by the stimulus process and checked by per-instance monitors.
module tb_duty_cycle_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       sig_a, clr_a, ready_a, mv_a, ovf_a, drop_a, act_a;
   logic [7:0] hc_a, pc_a;
   logic       sig_b, clr_b, ready_b, mv_b, ovf_b, drop_b, act_b;
   logic [3:0] hc_b, pc_b;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] p;
      logic       o;
   } res_t;

   res_t q_a[$];
   res_t q_b[$];
   res_t e_a, e_b;

   always #5 clk = ~clk;

   duty_cycle_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .sig_in(sig_a), .clr(clr_a), .meas_ready(ready_a),
      .meas_valid(mv_a), .high_cnt(hc_a), .period_cnt(pc_a), .meas_ovf(ovf_a),
      .drop_flag(drop_a), .active(act_a)
   );

   duty_cycle_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .sig_in(sig_b), .clr(clr_b), .meas_ready(ready_b),
      .meas_valid(mv_b), .high_cnt(hc_b), .period_cnt(pc_b), .meas_ovf(ovf_b),
      .drop_flag(drop_b), .active(act_b)
   );

   // Monitors: a transfer happens at the next posedge when valid&ready here.
   always @(negedge clk) begin
      if (mv_a && ready_a) begin
         tests++;
         if (q_a.size() == 0) begin
            fails++;
            $display("FAIL dut_a unexpected result: got h=%0d p=%0d ovf=%0d, none expected",
                     hc_a, pc_a, ovf_a);
         end else begin
            e_a = q_a.pop_front();
            if ({hc_a, pc_a, ovf_a} !== e_a) begin
               fails++;
               $display("FAIL dut_a result: got h=%0d p=%0d ovf=%0d, expected h=%0d p=%0d ovf=%0d",
                        hc_a, pc_a, ovf_a, e_a.h, e_a.p, e_a.o);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mv_b && ready_b) begin
         tests++;
         if (q_b.size() == 0) begin
            fails++;
            $display("FAIL dut_b unexpected result: got h=%0d p=%0d ovf=%0d, none expected",
                     hc_b, pc_b, ovf_b);
         end else begin
            e_b = q_b.pop_front();
            if ({4'b0, hc_b, 4'b0, pc_b, ovf_b} !== e_b) begin
               fails++;
               $display("FAIL dut_b result: got h=%0d p=%0d ovf=%0d, expected h=%0d p=%0d ovf=%0d",
                        hc_b, pc_b, ovf_b, e_b.h, e_b.p, e_b.o);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic a, input logic b);
      sig_a = a;
      sig_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic pat_a(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi; i++) drive(1'b1, 1'b0);
         for (int i = 0; i < lo; i++) drive(1'b0, 1'b0);
      end
   endtask

   task automatic pat_b(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi; i++) drive(1'b0, 1'b1);
         for (int i = 0; i < lo; i++) drive(1'b0, 1'b0);
      end
   endtask

   task automatic push_a(input int h, input int p, input logic o, input int n);
      for (int i = 0; i < n; i++) q_a.push_back('{h: 8'(h), p: 8'(p), o: o});
   endtask

   task automatic push_b(input int h, input int p, input logic o, input int n);
      for (int i = 0; i < n; i++) q_b.push_back('{h: 8'(h), p: 8'(p), o: o});
   endtask

   task automatic do_clr_a();
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      clr_a = 1'b1;
      drive(1'b0, 1'b0);
      clr_a = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sig_a = 1'b0; sig_b = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset meas_valid", int'(mv_a), 0);
      chk("reset high_cnt", int'(hc_a), 0);
      chk("reset period_cnt", int'(pc_a), 0);
      chk("reset meas_ovf", int'(ovf_a), 0);
      chk("reset drop_flag", int'(drop_a), 0);
      chk("reset active", int'(act_a), 0);
      chk("reset b meas_valid", int'(mv_b), 0);
      rst = 1'b0;
      drive(1'b0, 1'b0);

      // 25% waveform: first rise only starts measuring
      push_a(1, 4, 1'b0, 5);
      pat_a(1, 3, 6);
      chk("25pct active", int'(act_a), 1);

      // 5 high / 5 low
      do_clr_a();
      chk("clr active", int'(act_a), 0);
      push_a(5, 10, 1'b0, 3);
      pat_a(5, 5, 4);
      chk("5/5 drop_flag", int'(drop_a), 0);

      // CNT_W=4 saturation, then a normal period clears meas_ovf
      push_b(3, 15, 1'b1, 3);
      push_b(3, 10, 1'b0, 1);
      pat_b(3, 17, 3);
      pat_b(3, 7, 2);
      chk("sat drop_flag", int'(drop_b), 0);

      // Backpressure: first result held, later ones dropped
      do_clr_a();
      ready_a = 1'b0;
      push_a(1, 4, 1'b0, 1);
      pat_a(1, 3, 4);
      chk("bp meas_valid held", int'(mv_a), 1);
      chk("bp drop_flag", int'(drop_a), 1);
      chk("bp high_cnt", int'(hc_a), 1);
      chk("bp period_cnt", int'(pc_a), 4);
      ready_a = 1'b1;
      drive(1'b0, 1'b0);
      chk("bp meas_valid after accept", int'(mv_a), 0);
      chk("bp drop_flag sticky", int'(drop_a), 1);
      push_a(1, 5, 1'b0, 1);
      push_a(1, 4, 1'b0, 1);
      pat_a(1, 3, 2);

      // clr while a result is pending and drop_flag is set
      ready_a = 1'b0;
      pat_a(1, 3, 1);
      chk("pre-clr meas_valid", int'(mv_a), 1);
      chk("pre-clr drop_flag", int'(drop_a), 1);
      clr_a = 1'b1;
      drive(1'b0, 1'b0);
      clr_a = 1'b0;
      chk("clr meas_valid", int'(mv_a), 0);
      chk("clr drop_flag", int'(drop_a), 0);
      chk("clr active", int'(act_a), 0);
      ready_a = 1'b1;
      push_a(1, 4, 1'b0, 2);
      pat_a(1, 3, 3);

      // Reset in the low phase of a 5/5 period
      do_clr_a();
      push_a(5, 10, 1'b0, 2);
      pat_a(5, 5, 2);
      pat_a(5, 2, 1);
      chk("pre-rst high_cnt", int'(hc_a), 5);
      rst = 1'b1;
      #1;
      chk("rst meas_valid", int'(mv_a), 0);
      chk("rst high_cnt", int'(hc_a), 0);
      chk("rst period_cnt", int'(pc_a), 0);
      chk("rst active", int'(act_a), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pat_a(0, 3, 1);
      push_a(5, 10, 1'b0, 2);
      pat_a(5, 5, 3);

      repeat (4) drive(1'b0, 1'b0);
      chk("dut_a results outstanding", q_a.size(), 0);
      chk("dut_b results outstanding", q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
